pipe_barrel_shifter: RTL and testbench
======================================

# pipe_barrel_shifter

Parametrised, pipelined barrel shifter/rotator. It is the sequential successor to the 4-bit combinational rotator. It accepts a `WIDTH`-bit word, a shift amount and a mode over a valid/ready handshake, and applies one power-of-two shift stage per pipeline register. It returns results in order with full backpressure support. It sits between a producer and a consumer on the datapath and sustains one word per cycle.

## Interface
- `WIDTH`, default 8: data width in bits. Must be a power of two, ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. This is also the pipeline depth. Derived; do not override.
- `clk  input  1`: single clock. All state updates on its rising edge.
- `rst  input  1`: reset, synchronous, active-high.
- `in_valid  input  1`: an input word is presented.
- `in_ready  output  1`: the block can accept a word this cycle.
- `in_data  input  WIDTH`: operand.
- `in_amt  input  SHW`: shift amount, 0..WIDTH-1.
- `in_mode  input  2`: operation select.
  - 00 = ROL (rotate left)
  - 01 = ROR (rotate right)
  - 10 = SHL (logical left, zero fill)
  - 11 = SAR (arithmetic right, sign fill)
- `out_valid  output  1`: a result is presented.
- `out_ready  input  1`: the consumer accepts the result this cycle.
- `out_data  output  WIDTH`: result.

## Operation
- Pipeline structure:
  - `SHW` register stages, indexed k = 0..SHW-1.
  - Each stage holds `v[k]`, data, the remaining amount bits and the mode.
- Transfer rules:
  - A word is accepted when `in_valid & in_ready` is true at a rising edge.
  - Stage 0 loads `in_data` with shift by bit 0 of `in_amt` already applied.
  - Stage k (k ≥ 1) loads stage k-1's data shifted by 2^k when amount bit k is set; otherwise it passes the data unchanged.
- Per-bit mapping for a 2^k step:
  - ROL: `q[i] = d[(i - 2^k) mod WIDTH]`. Shift amount 1 gives `q[1] = d[0]`, `q[0] = d[WIDTH-1]`.
  - ROR: `q[i] = d[(i + 2^k) mod WIDTH]`.
  - SHL: as ROL, but the low 2^k bits are 0.
  - SAR: as ROR, but the high 2^k bits equal the current `d[WIDTH-1]`. The original sign is preserved through all stages.
- Amount 0 in any mode passes data unchanged.
- Per-stage advance:
  - `adv[SHW-1] = out_ready | ~v[SHW-1]`.
  - `adv[k] = adv[k+1] | ~v[k]`.
  - `in_ready = adv[0] & ~rst`.
  - This is a combinational ready chain, with no skid buffer.
  - A stage whose `adv` is 0 holds its contents unchanged.
- Bubbles:
  - A stage that advances without a valid upstream word loads `v = 0`.
  - Bubbles collapse whenever a downstream stage is empty, even if `out_ready` = 0.
- `out_valid = v[SHW-1]` and `out_data` = the last-stage data, both direct from registers.
- `out_data` must stay stable while `out_valid & ~out_ready`.
- Ordering is strictly FIFO. There is no reordering and no drop.

## Timing
- Reset:
  - `rst` high at an edge clears all `v[k]` to 0 and last-stage data to 0.
  - Therefore `out_valid` = 0 and `out_data` = 0 in the cycle after reset.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after reset.
- Latency: a word accepted in cycle t appears with `out_valid` = 1 in cycle t+SHW (t+3 for WIDTH = 8), given no stall.
- Throughput: one word per cycle when `out_ready` is held high.
- Pipeline full:
  - All `v` = 1 with `out_ready` = 0 forces `in_ready` = 0 in that same cycle.
  - When `out_ready` rises, `in_ready` rises combinationally in the same cycle.
- Simultaneous accept and emit in one cycle is legal, and the occupancy is unchanged.
- Reset mid-operation: all in-flight words are discarded. No partial result is ever presented.
- `in_data`, `in_amt` and `in_mode` are don't-care when `in_valid` = 0.
- Behaviour is undefined only if `in_valid` is dropped or the inputs change without acceptance; the block still must not corrupt queued words.

## Test plan
All scenarios use WIDTH = 8.
- ROL: `in_data` = 0x96, `in_amt` = 3, mode 00 → `out_data` = 0xB4, `out_valid` 3 cycles after accept.
- ROR and zero amount:
  - 0x96, amt 1, mode 01 → 0x4B.
  - 0x96, amt 0 in each mode → 0x96.
- Shifts:
  - 0x96, amt 4, mode 10 → 0x60.
  - 0x96, amt 2, mode 11 → 0xE5.
  - 0x16, amt 7, mode 11 → 0x00.
  - 0x80, amt 7, mode 11 → 0xFF.
- Streaming with backpressure:
  - Stimulus: 6 back-to-back words (ROL by 0..5 of 0x01), `out_ready` low in cycles 4–8.
  - Response: results 0x01, 0x02, 0x04, 0x08, 0x10, 0x20 in order, none lost or duplicated.
  - `in_ready` drops once 3 words are held, and `out_data` is stable while stalled.
- Bubble collapse: accept 1 word, idle 2 cycles with `out_ready` low, then present more words. The block accepts until all 3 stages are full.
- Reset mid-flight:
  - Stimulus: 2 words in the pipe, then `rst` pulsed for 1 cycle.
  - Response: `out_valid` = 0 and `out_data` = 0 after reset, and neither word emerges.
  - A new word accepted afterwards returns correctly after 3 cycles.

Source files
------------

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter/rotator. Each register stage applies one power-of-two step.
// A valid/ready handshake with a combinational ready chain allows one word per cycle.
module pipe_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;

    // One 2^k step. SAR fills from the current top bit, which stays equal to the original sign.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       mode,
                                                    input int               k);
        int               s;
        logic [WIDTH-1:0] q;
        s = 1 << k;
        case (mode)
            MODE_ROL: q = (d << s) | (d >> (WIDTH - s));
            MODE_ROR: q = (d >> s) | (d << (WIDTH - s));
            MODE_SHL: q = d << s;
            default:  q = $unsigned($signed(d) >>> s);
        endcase
        return q;
    endfunction

    logic [SHW-1:0]   v;
    logic [SHW-1:0]   adv;
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [1:0]       mode_q [SHW];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic [SHW-1:0]   up_a;
        logic [1:0]       up_m;

        if (k == 0) begin : g_src
            assign up_v = in_valid;
            assign up_d = in_data;
            assign up_a = in_amt;
            assign up_m = in_mode;
        end else begin : g_src
            assign up_v = v[k-1];
            assign up_d = data_q[k-1];
            assign up_a = amt_q[k-1];
            assign up_m = mode_q[k-1];
        end

        // A stage may move when the output drains or any slot at or after it is empty.
        assign adv[k] = out_ready | ~(&v[SHW-1:k]);

        always_ff @(posedge clk) begin
            if (rst) begin
                v[k]      <= 1'b0;
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end else if (adv[k]) begin
                v[k]      <= up_v;
                data_q[k] <= up_a[k] ? shift_step(up_d, up_m, k) : up_d;
                amt_q[k]  <= up_a;
                mode_q[k] <= up_m;
            end
        end
    end

    assign in_ready  = adv[0] & ~rst;
    assign out_valid = v[SHW-1];
    assign out_data  = data_q[SHW-1];

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter: directed literal cases plus random traffic
// checked every cycle against a slot-position model with whole-word reference results.
module tb_pipe_barrel_shifter;

    localparam int W   = 8;
    localparam int SHW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [2:0]   in_amt = '0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;

    int errors = 0;
    int checks = 0;

    pipe_barrel_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        int           pos;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] got[$];
    bit           after_rst = 1'b0;
    bit           saw_stall = 1'b0;
    bit           ov_exp;
    bit           rdy_exp;
    ent_t         e;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference result for one operation.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int a, input logic [1:0] m);
        longint x, mask, r;
        x    = longint'(d);
        mask = (longint'(1) << W) - 1;
        case (m)
            2'b00:   r = (x << a) | (x >> (W - a));
            2'b01:   r = (x >> a) | (x << (W - a));
            2'b10:   r = x << a;
            default: r = d[W-1] ? ((x >> a) | (mask & ~(mask >> a))) : (x >> a);
        endcase
        return W'(r & mask);
    endfunction

    // Entry i (oldest first) stays put only when every slot ahead of it is occupied and the output stalls.
    always @(negedge clk) begin
        if (rst) begin
            check_output("in_ready_during_reset", 32'(in_ready), 32'd0);
            q.delete();
            after_rst = 1'b1;
        end else begin
            ov_exp  = (q.size() > 0) && (q[0].pos == SHW - 1);
            rdy_exp = out_ready || (q.size() < SHW);
            check_output("out_valid", 32'(out_valid), 32'(ov_exp));
            check_output("in_ready", 32'(in_ready), 32'(rdy_exp));
            if (ov_exp) check_output("out_data", 32'(out_data), 32'(q[0].val));
            if (after_rst) begin
                check_output("out_data_after_reset", 32'(out_data), 32'd0);
                after_rst = 1'b0;
            end
            if (!in_ready) saw_stall = 1'b1;
            for (int i = 0; i < q.size(); i++) begin
                if (out_ready || (i != SHW - 1 - q[i].pos)) q[i].pos = q[i].pos + 1;
            end
            if (q.size() > 0 && q[0].pos == SHW) begin
                got.push_back(q[0].val);
                void'(q.pop_front());
            end
            if (in_valid && rdy_exp) begin
                e.val = ref_op(in_data, int'(in_amt), in_mode);
                e.pos = 0;
                q.push_back(e);
            end
        end
    end

    task automatic apply_stimulus(input logic [W-1:0] d, input int a, input logic [1:0] m);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = 3'(a);
        in_mode  = m;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        check_output("accept_within_bound", 32'(done), 32'd1);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic expect_out(input logic [W-1:0] exp, input int lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = out_valid;
        end
        check_output("latency", 32'(n), 32'(lat));
        check_output("result", 32'(out_data), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 40 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check_output("drained", 32'(q.size()), 32'd0);
    endtask

    logic [W-1:0] bubble_exp [3] = '{8'h02, 8'h03, 8'hC0};
    logic [1:0]   mode_v;
    int           seen_v;
    bit           acc;

    initial begin
        check_output("model_rol", 32'(ref_op(8'h96, 3, 2'b00)), 32'hB4);
        check_output("model_sar", 32'(ref_op(8'h96, 2, 2'b11)), 32'hE5);
        check_output("model_sar_neg", 32'(ref_op(8'h80, 7, 2'b11)), 32'hFF);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_out_data", 32'(out_data), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        apply_stimulus(8'h96, 3, 2'b00); expect_out(8'hB4, SHW);
        apply_stimulus(8'h96, 1, 2'b01); expect_out(8'h4B, SHW);
        for (int m = 0; m < 4; m++) begin
            mode_v = 2'(m);
            apply_stimulus(8'h96, 0, mode_v); expect_out(8'h96, SHW);
        end
        apply_stimulus(8'h96, 4, 2'b10); expect_out(8'h60, SHW);
        apply_stimulus(8'h96, 2, 2'b11); expect_out(8'hE5, SHW);
        apply_stimulus(8'h16, 7, 2'b11); expect_out(8'h00, SHW);
        apply_stimulus(8'h80, 7, 2'b11); expect_out(8'hFF, SHW);

        // Streaming: six back-to-back words with the consumer stalled for five cycles.
        got.delete();
        saw_stall = 1'b0;
        fork
            for (int i = 0; i < 6; i++) apply_stimulus(8'h01, i, 2'b00);
            begin
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();
        check_output("stream_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check_output("stream_order", 32'(got[i]), 32'(1 << i));
        check_output("stream_in_ready_dropped", 32'(saw_stall), 32'd1);

        // Bubble collapse with the consumer stalled.
        got.delete();
        out_ready = 1'b0;
        apply_stimulus(8'h81, 1, 2'b10);
        repeat (2) begin @(posedge clk); #1; end
        apply_stimulus(8'h81, 1, 2'b00);
        apply_stimulus(8'h81, 1, 2'b01);
        @(negedge clk);
        check_output("bubble_full_in_ready", 32'(in_ready), 32'd0);
        check_output("bubble_full_out_valid", 32'(out_valid), 32'd1);
        check_output("bubble_full_out_data", 32'(out_data), 32'h02);
        @(posedge clk);
        #1;
        drain();
        check_output("bubble_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check_output("bubble_order", 32'(got[i]), 32'(bubble_exp[i]));

        // Reset with two words in flight.
        got.delete();
        apply_stimulus(8'h55, 1, 2'b00);
        apply_stimulus(8'h33, 2, 2'b01);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("midreset_out_valid", 32'(out_valid), 32'd0);
        check_output("midreset_out_data", 32'(out_data), 32'd0);
        seen_v = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen_v++;
        end
        check_output("midreset_no_emit", 32'(seen_v), 32'd0);
        check_output("midreset_got", 32'(got.size()), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(8'h96, 5, 2'b01); expect_out(8'hB4, SHW);

        // Random traffic; inputs are held until accepted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = W'($urandom);
                in_amt   = 3'($urandom_range(0, W - 1));
                in_mode  = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
